// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection and branch resolution.
// A taken branch redirects fetch in the same cycle. The instruction fetched
// while the branch sits in ID is a delay slot and is always kept.
module if_id_stage #(
    parameter logic [4:0] ZERO_REG = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        reg_zero,
    input  logic        flag_n,
    input  logic        flag_v,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    output logic [63:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic [63:0] br_pc,
    output logic        br_taken,
    output logic        pc_en,
    output logic        id_bubble
);

    // Decoded class of the instruction currently in ID
    typedef struct packed {
        logic b;
        logic cbz;
        logic blt;
        logic stur;
    } dec_t;

    dec_t        dec;
    logic        stall;
    logic [4:0]  rn, rm, rt;
    logic [63:0] off_b, off_cb;

    // IF/ID register; a stall freezes it so the load-use consumer retries next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_pc    <= 64'h0;
            id_instr <= 32'h0;
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_pc    <= if_pc;
            id_instr <= if_instr;
            id_valid <= 1'b1;
        end
    end

    assign rn = id_instr[9:5];
    assign rm = id_instr[20:16];
    assign rt = id_instr[4:0];

    // Opcode decode for the control-flow and store forms that matter here
    always_comb begin
        dec      = '0;
        dec.b    = (id_instr[31:26] == 6'b000101);
        dec.cbz  = (id_instr[31:24] == 8'b10110100);
        dec.blt  = (id_instr[31:24] == 8'b01010100) && (rt == 5'b01011);
        dec.stur = (id_instr[31:21] == 11'b11111000000);
    end

    // Load-use hazard: Rt is a source only for CBZ and STUR. The zero register
    // never creates a dependency. One bubble is always enough because the
    // bubble itself clears ex_mem_read the following cycle.
    always_comb begin
        stall = 1'b0;
        if (id_valid && ex_mem_read && (ex_rd != ZERO_REG)) begin
            stall = (ex_rd == rn) || (ex_rd == rm) ||
                    ((dec.cbz || dec.stur) && (ex_rd == rt));
        end
    end

    assign pc_en     = ~stall;
    assign id_bubble = stall | ~id_valid;

    // Sign-extended word offsets; the adds wrap modulo 2^64 by width
    assign off_b  = {{36{id_instr[25]}}, id_instr[25:0], 2'b00};
    assign off_cb = {{43{id_instr[23]}}, id_instr[23:5], 2'b00};

    // Zero-cycle redirect straight into the fetch mux
    always_comb begin
        br_pc    = dec.b ? (id_pc + off_b) : (id_pc + off_cb);
        br_taken = id_valid && !stall &&
                   (dec.b || (dec.cbz && reg_zero) || (dec.blt && (flag_n != flag_v)));
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, vector table, and multi-cycle sequences.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        reg_zero, flag_n, flag_v, ex_mem_read;
    logic [4:0]  ex_rd;
    logic [63:0] id_pc, br_pc;
    logic [31:0] id_instr;
    logic        id_valid, br_taken, pc_en, id_bubble;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] ADD_152  = 32'h8B0200A1; // ADD X1,X5,X2
    localparam logic [31:0] ADD_1Z2  = 32'h8B0203E1; // ADD X1,XZR,X2
    localparam logic [31:0] ADD_123  = 32'h8B030041; // ADD X1,X2,X3
    localparam logic [31:0] NOP      = 32'h8B1F03FF; // ADD XZR,XZR,XZR
    localparam logic [31:0] B_M2     = 32'h17FFFFFE; // B -2
    localparam logic [31:0] B_P256   = 32'h14000100; // B +256
    localparam logic [31:0] CBZ3_4   = 32'hB4000083; // CBZ X3,+4
    localparam logic [31:0] CBZ3_M1  = 32'hB4FFFFE3; // CBZ X3,-1
    localparam logic [31:0] BLT_1    = 32'h5400002B; // B.LT +1
    localparam logic [31:0] BEQ_1    = 32'h54000020; // B.EQ +1
    localparam logic [31:0] STUR7    = 32'hF8000047; // STUR X7,[X2]

    if_id_stage #(.ZERO_REG(5'd31)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr),
        .reg_zero(reg_zero), .flag_n(flag_n), .flag_v(flag_v),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid),
        .br_pc(br_pc), .br_taken(br_taken), .pc_en(pc_en), .id_bubble(id_bubble)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        rz, fn, fv, mr;
        logic [4:0]  rd;
        logic        exp_stall;
        logic        exp_taken;
        logic [63:0] exp_brpc;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Put pc/instr into ID with no hazard pending
    task automatic load(input logic [63:0] pc, input logic [31:0] instr);
        @(negedge clk);
        ex_mem_read = 1'b0;
        reg_zero = 1'b0; flag_n = 1'b0; flag_v = 1'b0;
        if_pc = pc; if_instr = instr;
        @(posedge clk); #1;
    endtask

    initial begin
        vt[0]  = '{64'h10, ADD_152, 0,0,0, 0, 5'd0,  0, 0, 64'h0};
        vt[1]  = '{64'h10, ADD_152, 0,0,0, 1, 5'd5,  1, 0, 64'h0};
        vt[2]  = '{64'h10, ADD_152, 0,0,0, 1, 5'd2,  1, 0, 64'h0};
        vt[3]  = '{64'h10, ADD_152, 0,0,0, 1, 5'd1,  0, 0, 64'h0};
        vt[4]  = '{64'h20, ADD_1Z2, 0,0,0, 1, 5'd31, 0, 0, 64'h0};
        vt[5]  = '{64'h200, CBZ3_4, 1,0,0, 0, 5'd0,  0, 1, 64'h210};
        vt[6]  = '{64'h200, CBZ3_4, 0,0,0, 0, 5'd0,  0, 0, 64'h0};
        vt[7]  = '{64'h200, CBZ3_4, 1,0,0, 1, 5'd3,  1, 0, 64'h0};
        vt[8]  = '{64'h40, STUR7,   0,0,0, 1, 5'd7,  1, 0, 64'h0};
        vt[9]  = '{64'hFFFF_FFFF_FFFF_FFFC, BLT_1, 0,1,0, 0, 5'd0, 0, 1, 64'h0};
        vt[10] = '{64'hFFFF_FFFF_FFFF_FFFC, BLT_1, 0,1,1, 0, 5'd0, 0, 0, 64'h0};
        vt[11] = '{64'hFFFF_FFFF_FFFF_FFFC, BLT_1, 0,0,1, 0, 5'd0, 0, 1, 64'h0};
        vt[12] = '{64'h80, BEQ_1,   0,1,0, 0, 5'd0,  0, 0, 64'h0};
        vt[13] = '{64'h100, B_M2,   0,0,0, 1, 5'd0,  0, 1, 64'hF8};
        vt[14] = '{64'h1000, B_P256,0,0,0, 0, 5'd0,  0, 1, 64'h1400};
        vt[15] = '{64'h0, CBZ3_M1,  1,0,0, 0, 5'd0,  0, 1, 64'hFFFF_FFFF_FFFF_FFFC};

        reset = 1'b1; if_pc = '0; if_instr = '0; reg_zero = 0;
        flag_n = 0; flag_v = 0; ex_mem_read = 1'b1; ex_rd = 5'd0;

        // Reset state
        @(posedge clk); @(negedge clk);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_pc_en", pc_en, 1);
        chk("rst_bubble", id_bubble, 1);
        chk("rst_br_taken", br_taken, 0);

        // Release, then first capture
        reset = 1'b0; ex_mem_read = 1'b0; if_pc = 64'h0; if_instr = ADD_152;
        #1;
        chk("rel_pc_en", pc_en, 1);
        chk("rel_bubble", id_bubble, 1);
        chk("rel_br_taken", br_taken, 0);
        @(posedge clk); #1;
        chk("first_id_pc", id_pc, 0);
        chk("first_id_valid", id_valid, 1);
        chk("first_bubble", id_bubble, 0);
        chk("first_br_taken", br_taken, 0);

        // Vector table: load, apply side inputs, check, then one more edge
        for (int i = 0; i < 16; i++) begin
            load(vt[i].pc, vt[i].instr);
            reg_zero = vt[i].rz; flag_n = vt[i].fn; flag_v = vt[i].fv;
            ex_mem_read = vt[i].mr; ex_rd = vt[i].rd;
            if_pc = vt[i].pc + 64'd4; if_instr = NOP;
            #1;
            chk($sformatf("v%0d_pc_en", i), pc_en, !vt[i].exp_stall);
            chk($sformatf("v%0d_bubble", i), id_bubble, vt[i].exp_stall);
            chk($sformatf("v%0d_taken", i), br_taken, vt[i].exp_taken);
            if (vt[i].exp_taken)
                chk($sformatf("v%0d_br_pc", i), br_pc, vt[i].exp_brpc);
            @(posedge clk); #1;
            chk($sformatf("v%0d_next_pc", i), id_pc,
                vt[i].exp_stall ? vt[i].pc : vt[i].pc + 64'd4);
            chk($sformatf("v%0d_next_instr", i), id_instr,
                vt[i].exp_stall ? vt[i].instr : NOP);
        end

        // Branch with delay slot: slot instruction at 0x104 is captured
        load(64'h100, B_M2);
        chk("ds_taken", br_taken, 1);
        chk("ds_br_pc", br_pc, 64'hF8);
        if_pc = 64'h104; if_instr = ADD_123;
        @(posedge clk); #1;
        chk("ds_id_pc", id_pc, 64'h104);
        chk("ds_id_instr", id_instr, ADD_123);
        chk("ds_valid", id_valid, 1);
        chk("ds_taken_after", br_taken, 0);

        // Load-use stall holds one edge, then resumes
        load(64'h300, ADD_152);
        ex_mem_read = 1'b1; ex_rd = 5'd5; if_pc = 64'h304; if_instr = NOP;
        #1;
        chk("st_pc_en", pc_en, 0);
        chk("st_bubble", id_bubble, 1);
        @(posedge clk); #1;
        chk("st_hold_pc", id_pc, 64'h300);
        chk("st_hold_instr", id_instr, ADD_152);
        ex_mem_read = 1'b0;
        #1;
        chk("st_resume_pc_en", pc_en, 1);
        chk("st_resume_bubble", id_bubble, 0);
        @(posedge clk); #1;
        chk("st_resume_id_pc", id_pc, 64'h304);

        // Stalled CBZ is not taken until the stall clears
        load(64'h200, CBZ3_4);
        reg_zero = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3; if_pc = 64'h204;
        #1;
        chk("scbz_taken_stalled", br_taken, 0);
        @(posedge clk); #1;
        chk("scbz_held", id_pc, 64'h200);
        ex_mem_read = 1'b0;
        #1;
        chk("scbz_taken_clear", br_taken, 1);
        chk("scbz_br_pc", br_pc, 64'h210);

        // Reset during a stall discards held contents
        load(64'h400, ADD_152);
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        #1;
        chk("mrst_stalled", pc_en, 0);
        #2 reset = 1'b1;
        #1;
        chk("mrst_async_valid", id_valid, 0);
        chk("mrst_async_pc", id_pc, 0);
        chk("mrst_pc_en", pc_en, 1);
        chk("mrst_bubble", id_bubble, 1);
        @(negedge clk);
        reset = 1'b0; if_pc = 64'h500; if_instr = ADD_123;
        @(posedge clk); #1;
        chk("mrst_cap_pc", id_pc, 64'h500);
        chk("mrst_cap_instr", id_instr, ADD_123);
        chk("mrst_cap_valid", id_valid, 1);
        chk("mrst_cap_pc_en", pc_en, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter ZERO_REG, default 5'd31, register index that never causes a hazard stall.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port if_pc  input  64  PC of instruction currently fetched.
REQ-005 SHALL have port if_instr  input  32  instruction word currently fetched.
REQ-006 SHALL have port reg_zero  input  1  forwarded ID-stage read of Rt (instr[4:0]) equals zero.
REQ-007 SHALL have ports flag_n, flag_v  input  1 each  current N and V condition flags.
REQ-008 SHALL have port ex_mem_read  input  1  instruction in EX is a load.
REQ-009 SHALL have port ex_rd  input  5  destination register of instruction in EX.
REQ-010 SHALL have ports id_pc  output  64, id_instr  output  32, id_valid  output  1  registered IF/ID contents.
REQ-011 SHALL have ports br_pc  output  64, br_taken  output  1  branch redirect to fetch.
REQ-012 SHALL have ports pc_en  output  1  fetch PC update enable, and id_bubble  output  1  zero ID control into ID/EX.

Function
REQ-013 SHALL capture if_pc, if_instr into id_pc, id_instr and set id_valid=1 on every rising edge where stall=0.
REQ-014 SHALL hold id_pc, id_instr, id_valid unchanged on a rising edge where stall=1.
REQ-015 SHALL decode from id_instr: B = [31:26]==6'b000101; CBZ = [31:24]==8'b10110100; B.LT = [31:24]==8'b01010100 and [4:0]==5'b01011; STUR = [31:21]==11'b11111000000.
REQ-016 SHALL compute stall combinationally = id_valid & ex_mem_read & ex_rd!=ZERO_REG & (ex_rd==id_instr[9:5] | ex_rd==id_instr[20:16] | ((CBZ|STUR) & ex_rd==id_instr[4:0])).
REQ-017 SHALL drive pc_en = ~stall and id_bubble = stall | ~id_valid.
REQ-018 SHALL compute br_pc = id_pc + (sign-extended instr[25:0] << 2) for B, else id_pc + (sign-extended instr[23:5] << 2), modulo 2^64 (wrap-around, no overflow flag).
REQ-019 SHALL drive br_taken = id_valid & ~stall & (B | (CBZ & reg_zero) | (B.LT & (flag_n != flag_v))).
REQ-020 SHALL use delay-slot semantics: the instruction fetched while a branch is in ID is captured normally and never flushed.
REQ-021 SHALL fully cover a stall in one cycle: the bubble sent to EX clears ex_mem_read on the next cycle, so no stall counter is kept.
REQ-022 SHALL treat non-branch, non-stalled instructions as br_taken=0; br_pc value is don't-care when br_taken=0.
REQ-023 SHALL produce br_pc and br_taken combinationally from registered state and inputs in the same cycle (zero-cycle redirect into fetch mux).

Reset
REQ-024 SHALL, while reset=1, asynchronously force id_pc=64'h0, id_instr=32'h0, id_valid=0.
REQ-025 SHALL, during and immediately after reset, output br_taken=0, id_bubble=1, pc_en=1.
REQ-026 SHALL, on reset asserted mid-stall, discard held contents; first post-reset edge captures if_pc/if_instr.

Verification
REQ-027 SHALL cover: reset release, if_pc=0, if_instr=ADD -> after edge id_pc=0, id_valid=1, id_bubble=0, br_taken=0.
REQ-028 SHALL cover: id_pc=0x100, B imm26=-2 -> br_taken=1, br_pc=0xF8; next edge captures delay-slot instruction at 0x104.
REQ-029 SHALL cover: CBZ X3 imm19=4 at id_pc=0x200, reg_zero=1 -> br_pc=0x210, br_taken=1; reg_zero=0 -> br_taken=0.
REQ-030 SHALL cover: ex_mem_read=1, ex_rd=5, id_instr ADD X1,X5,X2 -> pc_en=0, id_bubble=1, id_pc/id_instr held one edge; next cycle ex_mem_read=0 -> resumes.
REQ-031 SHALL cover: ex_mem_read=1, ex_rd=31 matching Rn -> no stall; stalled CBZ with reg_zero=1 -> br_taken=0 until stall clears.
REQ-032 SHALL cover: B.LT at id_pc=0xFFFFFFFFFFFFFFFC, imm19=1, flag_n=1, flag_v=0 -> br_taken=1, br_pc=0x0 (wrap).
